// File: rtl/round_countdown_timer.sv
// Round countdown timer for the two-digit round-time display.
// Counts elapsed seconds 0..ROUND_SEC from a 1 s prescaler tick, handles
// start/pause/clear/kill, and free-runs a digit-scan multiplexer.
module round_countdown_timer #(
  parameter int CLK_HZ    = 50000000,
  parameter int SCAN_DIV  = 50000,
  parameter int ROUND_SEC = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic       kill,
  output logic [3:0] In,
  output logic       flag,
  output logic       digit,
  output logic [1:0] seg_en_n,
  output logic       time_up,
  output logic       running
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_HZ - 1);
  localparam logic [SW-1:0] SCAN_MAX   = SW'(SCAN_DIV - 1);
  localparam logic [3:0]    ROUND_LAST = 4'(ROUND_SEC - 1);
  localparam logic [3:0]    ROUND_END  = 4'(ROUND_SEC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          flag_q, flag_d;
  logic          time_up_q, time_up_d;
  logic          running_q, running_d;
  logic [SW-1:0] scan_q, scan_d;
  logic          digit_q, digit_d;
  logic [1:0]    seg_q, seg_d;
  logic          tick;
  logic          scan_wrap;

  // Next-state, elapsed count and prescaler; priority clear > kill > start > pause
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    presc_d = presc_q;
    tick    = (state_q == RUN) && (presc_q == PRESC_MAX);

    unique case (state_q)
      IDLE: begin
        cnt_d   = '0;
        presc_d = '0;
        if (!clear && start) begin
          state_d = RUN;
        end
      end

      RUN: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (tick) begin
          cnt_d = cnt_q + 4'd1;
        end
        if (clear) begin
          state_d = IDLE;
          cnt_d   = '0;
          presc_d = '0;
        end else if (kill) begin
          // Abort keeps the count reached so far, even on a tick cycle.
          state_d = DONE;
          cnt_d   = cnt_q;
          presc_d = presc_q;
        end else if (tick && (cnt_q == ROUND_LAST)) begin
          state_d = DONE;
          cnt_d   = ROUND_END;
        end else if (!start && pause) begin
          // Any coincident tick has already been counted above.
          state_d = PAUSE;
        end
      end

      PAUSE: begin
        if (clear) begin
          state_d = IDLE;
          cnt_d   = '0;
          presc_d = '0;
        end else if (kill) begin
          state_d = DONE;
        end else if (start) begin
          state_d = RUN;
        end
      end

      DONE: begin
        if (clear) begin
          state_d = IDLE;
          cnt_d   = '0;
          presc_d = '0;
        end else if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          presc_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        presc_d = '0;
      end
    endcase

    flag_d    = (state_d == DONE);
    running_d = (state_d == RUN);
    time_up_d = (state_d == DONE) && (state_q != DONE);
  end

  // Digit-scan counter; digit and enables are derived together from the wrap
  always_comb begin
    scan_wrap = (scan_q == SCAN_MAX);
    scan_d    = scan_wrap ? '0 : scan_q + SW'(1);
    digit_d   = scan_wrap ? ~digit_q : digit_q;
    seg_d     = digit_d ? 2'b01 : 2'b10;
  end

  // Round state machine and its registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      cnt_q     <= '0;
      flag_q    <= 1'b0;
      time_up_q <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      flag_q    <= flag_d;
      time_up_q <= time_up_d;
      running_q <= running_d;
    end
  end

  // Free-running scan registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_q  <= '0;
      digit_q <= 1'b0;
      seg_q   <= 2'b10;
    end else begin
      scan_q  <= scan_d;
      digit_q <= digit_d;
      seg_q   <= seg_d;
    end
  end

  assign In       = cnt_q;
  assign flag     = flag_q;
  assign time_up  = time_up_q;
  assign running  = running_q;
  assign digit    = digit_q;
  assign seg_en_n = seg_q;

endmodule
